// File: rtl/sram_fifo_ctrl.sv
// rtl/sram_fifo_ctrl.sv - FIFO controller over a 1W1R SRAM macro with a 2-entry prefetch buffer.
// Optional level/almost_full outputs are enabled by defining SRAM_FIFO_LEVEL_EN.
module sram_fifo_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 11,
  parameter int NUM_WMASKS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DATA_WIDTH-1:0]   in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    sram_csb0,
  output logic [NUM_WMASKS-1:0]   sram_wmask0,
  output logic [ADDR_WIDTH-1:0]   sram_addr0,
  output logic [DATA_WIDTH-1:0]   sram_din0,
  output logic                    sram_csb1,
  output logic [ADDR_WIDTH-1:0]   sram_addr1,
  input  logic [DATA_WIDTH-1:0]   sram_dout1
`ifdef SRAM_FIFO_LEVEL_EN
  ,
  output logic [ADDR_WIDTH+1:0]   level,
  output logic                    almost_full
`endif
);

  localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};

  logic [ADDR_WIDTH-1:0] wptr, rptr, addr0_q, addr1_q;
  logic [DATA_WIDTH-1:0] din0_q, pbuf0, pbuf1;
  logic [ADDR_WIDTH:0]   scount, scount_nxt;
  logic [1:0]            pbuf_count, pbuf_count_nxt;
  logic                  rd_pending, rd_pending_nxt;
  logic                  push, pop, rd_issue;

  // scount is registered, so a word written this cycle is not yet counted
  // and cannot be read on the same edge it is written.
  assign in_ready  = (scount != DEPTH);
  assign push      = in_valid & in_ready & ~rst;
  assign out_valid = (pbuf_count != 2'd0);
  assign out_data  = pbuf0;
  assign pop       = out_valid & out_ready;
  assign rd_issue  = ~rst && (scount != '0) && ((pbuf_count + {1'b0, rd_pending}) < 2'd2);

  assign sram_wmask0 = '1;
  assign sram_csb0   = ~push;
  assign sram_addr0  = push ? wptr : addr0_q;
  assign sram_din0   = push ? in_data : din0_q;
  assign sram_csb1   = ~rd_issue;
  assign sram_addr1  = rd_issue ? rptr : addr1_q;

  always_comb begin
    scount_nxt     = scount;
    pbuf_count_nxt = pbuf_count;
    rd_pending_nxt = rd_issue;
    case ({push, rd_issue})
      2'b10:   scount_nxt = scount + 1'b1;
      2'b01:   scount_nxt = scount - 1'b1;
      default: scount_nxt = scount;
    endcase
    case ({rd_pending, pop})
      2'b10:   pbuf_count_nxt = pbuf_count + 2'd1;
      2'b01:   pbuf_count_nxt = pbuf_count - 2'd1;
      default: pbuf_count_nxt = pbuf_count;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      rptr       <= '0;
      addr0_q    <= '0;
      addr1_q    <= '0;
      din0_q     <= '0;
      scount     <= '0;
      pbuf_count <= 2'd0;
      rd_pending <= 1'b0;
      pbuf0      <= '0;
      pbuf1      <= '0;
    end else begin
      scount     <= scount_nxt;
      pbuf_count <= pbuf_count_nxt;
      rd_pending <= rd_pending_nxt;
      if (push) begin
        wptr    <= wptr + 1'b1;
        addr0_q <= wptr;
        din0_q  <= in_data;
      end
      if (rd_issue) begin
        rptr    <= rptr + 1'b1;
        addr1_q <= rptr;
      end
      // Macro read data is only valid at the edge right after a read issue.
      if (rd_pending && pop) begin
        if (pbuf_count == 2'd2) begin
          pbuf0 <= pbuf1;
          pbuf1 <= sram_dout1;
        end else begin
          pbuf0 <= sram_dout1;
        end
      end else if (rd_pending) begin
        if (pbuf_count == 2'd0) pbuf0 <= sram_dout1;
        else                    pbuf1 <= sram_dout1;
      end else if (pop) begin
        pbuf0 <= pbuf1;
      end
    end
  end

`ifdef SRAM_FIFO_LEVEL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level       <= '0;
      almost_full <= 1'b0;
    end else begin
      level       <= {1'b0, scount_nxt}
                   + {{ADDR_WIDTH{1'b0}}, pbuf_count_nxt}
                   + {{(ADDR_WIDTH+1){1'b0}}, rd_pending_nxt};
      almost_full <= (scount_nxt >= (DEPTH - (ADDR_WIDTH+1)'(4)));
    end
  end
`endif

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb/tb_sram_fifo_ctrl.sv - directed self-checking bench for sram_fifo_ctrl with a behavioural 1W1R SRAM.
module tb_sram_fifo_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready;
  logic [7:0]  in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_data;
  logic        sram_csb0, sram_csb1;
  logic [3:0]  sram_wmask0;
  logic [10:0] sram_addr0, sram_addr1;
  logic [7:0]  sram_din0, sram_dout1;
`ifdef SRAM_FIFO_LEVEL_EN
  logic [12:0] level;
  logic        almost_full;
`endif

  sram_fifo_ctrl dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_csb0(sram_csb0), .sram_wmask0(sram_wmask0), .sram_addr0(sram_addr0), .sram_din0(sram_din0),
    .sram_csb1(sram_csb1), .sram_addr1(sram_addr1), .sram_dout1(sram_dout1)
`ifdef SRAM_FIFO_LEVEL_EN
    , .level(level), .almost_full(almost_full)
`endif
  );

  always #5 clk = ~clk;

  logic [7:0] mem [0:2047];
  always @(posedge clk) begin
    if (!sram_csb0) mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= mem[sram_addr1];
  end

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  int wptr_m = 0, rptr_m = 0, occ = 0, stored = 0, n_push = 0, n_wrap = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_q.delete();
    wptr_m = 0; rptr_m = 0; occ = 0; stored = 0;
  endtask

  // Called at a negedge with inputs already set; observes the cycle, then advances to the next negedge.
  task automatic step();
    logic push_s, pop_s, rd_s;
    #1;
    push_s = in_valid & in_ready;
    pop_s  = out_valid & out_ready;
    rd_s   = !sram_csb1;
    chk("csb0", sram_csb0, !push_s);
    if (rd_s) begin
      chk("addr1", sram_addr1, rptr_m);
      chk("rd_occ_lt2", occ < 2, 1);
      chk("rd_has_word", stored > 0, 1);
      if (rptr_m == 2047) n_wrap++;
      rptr_m = (rptr_m + 1) % 2048;
      occ++;
      stored--;
    end
    if (push_s) begin
      chk("addr0", sram_addr0, wptr_m);
      chk("din0", sram_din0, in_data);
      chk("wmask0", sram_wmask0, 4'hF);
      wptr_m = (wptr_m + 1) % 2048;
      exp_q.push_back(in_data);
      stored++;
      n_push++;
    end
    if (pop_s) begin
      if (exp_q.size() == 0) chk("pop_unexpected", 1, 0);
      else chk("out_data", out_data, exp_q.pop_front());
      occ--;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drain();
    int guard;
    in_valid = 1'b0;
    out_ready = 1'b1;
    guard = 0;
    while (exp_q.size() > 0 && guard < 10000) begin
      step();
      guard++;
    end
    chk("drain_done", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = 8'h00;
    @(negedge clk); #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_csb0", sram_csb0, 1);
    chk("rst_csb1", sram_csb1, 1);
    chk("rst_wmask0", sram_wmask0, 4'hF);
    chk("rst_addr0", sram_addr0, 0);
    chk("rst_addr1", sram_addr1, 0);
    chk("rst_din0", sram_din0, 0);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("rst_level", level, 0);
    chk("rst_almost_full", almost_full, 0);
`endif
    @(negedge clk);
    rst = 1'b0;

    // single word: push at edge 1, read in cycle 2, visible after edge 3
    in_valid = 1'b1; in_data = 8'hA5; #1;
    chk("sw_csb0", sram_csb0, 0);
    chk("sw_addr0", sram_addr0, 0);
    chk("sw_csb1_c1", sram_csb1, 1);
    step();
    in_valid = 1'b0; #1;
    chk("sw_csb1_c2", sram_csb1, 0);
    chk("sw_addr1_c2", sram_addr1, 0);
    chk("sw_addr0_hold", sram_addr0, 0);
    chk("sw_din0_hold", sram_din0, 8'hA5);
    step();
    chk("sw_out_valid_c3", out_valid, 0);
    chk("sw_csb1_c3", sram_csb1, 1);
    step();
    chk("sw_out_valid", out_valid, 1);
    chk("sw_out_data", out_data, 8'hA5);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0; #1;
    chk("sw_empty", out_valid, 0);

    // reset mid-stream with one word buffered and one read in flight
    in_valid = 1'b1; in_data = 8'h11; step();
    in_data = 8'h22; step();
    in_valid = 1'b0; step();
    chk("mr_out_valid_pre", out_valid, 1);
    chk("mr_occ_pre", occ, 2);
    in_valid = 1'b1; in_data = 8'h77;
    #2 rst = 1'b1;
    #1;
    chk("mr_out_valid", out_valid, 0);
    chk("mr_csb0", sram_csb0, 1);
    chk("mr_csb1", sram_csb1, 1);
    chk("mr_in_ready", in_ready, 1);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    in_data = 8'h3C; step();
    in_valid = 1'b0; step();
    step();
    chk("mr_out_valid_post", out_valid, 1);
    chk("mr_out_data_post", out_data, 8'h3C);
    out_ready = 1'b1; step();
    out_ready = 1'b0;

    // fill: 2050 words, in_ready drops, two words prefetched
    for (int i = 0; i < 2050; i++) begin
      in_valid = 1'b1; in_data = i[7:0];
      #1 chk("fill_in_ready", in_ready, 1);
      step();
    end
    in_valid = 1'b0; #1;
    chk("full_in_ready", in_ready, 0);
    chk("full_prefetch2", occ, 2);
    chk("full_stored", stored, 2048);
    chk("full_out_data", out_data, 8'h00);
`ifdef SRAM_FIFO_LEVEL_EN
    chk("full_level", level, 2050);
    chk("full_almost_full", almost_full, 1);
`endif
    in_valid = 1'b1; in_data = 8'hEE; step();
    in_valid = 1'b0; out_ready = 1'b1; #1;
    chk("full_pop_in_ready", in_ready, 0);
    step();
    out_ready = 1'b0; #1;
    chk("full_after_pop_in_ready", in_ready, 0);
    chk("full_reissue", sram_csb1, 0);
    step();
    chk("full_reopen", in_ready, 1);
    drain();

    // wrap: continuous stream of 5000 words
    n_push = 0; n_wrap = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 20000 && n_push < 5000; c++) begin
      in_data = 8'((n_push * 7 + 3) & 255);
      step();
    end
    chk("wrap_pushed", n_push, 5000);
    drain();
    chk("wrap_addr1_wrapped", n_wrap > 0, 1);

    // back-pressure: 30% out_ready duty, 70% in_valid duty
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_data   = 8'($urandom_range(0, 255));
      out_ready = ($urandom_range(0, 99) < 30);
      step();
    end
    drain();
    #1;
    chk("final_out_valid", out_valid, 0);
    chk("final_occ", occ, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
